// File: rtl/instr_mem_loader.sv
// Instruction memory loader: streams 16-bit words into imem from address 0.
// Holds core_run low until a full program is written. Option: LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int         ADDR_WIDTH = 8,
    parameter int         DATA_WIDTH = 16,
    parameter logic [3:0] END_OPCODE = 4'hF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_wr_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_wr_data,
    output logic                  load_done,
    output logic                  core_run,
    output logic                  overflow_err,
`ifdef LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] load_checksum,
`endif
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERR
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  accept;
    logic                  is_end;
    logic                  at_last;
    logic                  restart;

    always_comb begin
        state_nx     = state;
        accept       = in_valid && (state == LOAD);
        is_end       = (in_data[DATA_WIDTH-1 -: 4] == END_OPCODE);
        at_last      = (addr == '1);
        restart      = load_start && (state != LOAD);
        in_ready     = (state == LOAD);
        load_done    = (state == DONE);
        overflow_err = (state == ERR);
        unique case (state)
            IDLE: begin
                if (load_start) state_nx = LOAD;
            end
            LOAD: begin
                // END wins over overflow when it lands on the last address
                if (accept && is_end)       state_nx = DONE;
                else if (accept && at_last) state_nx = ERR;
            end
            DONE, ERR: begin
                if (load_start) state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= '0;
            word_count   <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            core_run     <= 1'b0;
        end else begin
            state      <= state_nx;
            imem_wr_en <= accept;
            // release one cycle after the final write lands
            core_run   <= (state == DONE) && (state_nx == DONE);
            if (restart) begin
                addr       <= '0;
                word_count <= '0;
            end else if (accept) begin
                addr         <= addr + ADDR_WIDTH'(1);
                word_count   <= word_count + (ADDR_WIDTH+1)'(1);
                imem_wr_addr <= addr;
                imem_wr_data <= in_data;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset || restart) begin
            load_checksum <= '0;
        end else if (accept) begin
            load_checksum <= load_checksum ^ in_data;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a 4-word memory.
// Writes are captured by a monitor and checked against hand-computed vectors.
module tb_instr_mem_loader;

    localparam int AW = 2;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_start = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_wr_en;
    logic [AW-1:0] imem_wr_addr;
    logic [DW-1:0] imem_wr_data;
    logic          load_done;
    logic          core_run;
    logic          overflow_err;
    logic [AW:0]   word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] load_checksum;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] wq_a[$];
    logic [DW-1:0] wq_d[$];

    instr_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .END_OPCODE(4'hF)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_start  (load_start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .imem_wr_en  (imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .load_done   (load_done),
        .core_run    (core_run),
        .overflow_err(overflow_err),
`ifdef LOADER_CHECKSUM_EN
        .load_checksum(load_checksum),
`endif
        .word_count  (word_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (imem_wr_en) begin
            wq_a.push_back(imem_wr_addr);
            wq_d.push_back(imem_wr_data);
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n, input logic [4*DW-1:0] exp);
        chk({tag, "_nwr"}, 32'(wq_a.size()), 32'(n));
        for (int i = 0; i < n && i < wq_a.size(); i++) begin
            chk({tag, "_addr"}, 32'(wq_a[i]), 32'(i));
            chk({tag, "_data"}, 32'(wq_d[i]), 32'(exp[i*DW +: DW]));
        end
        wq_a.delete();
        wq_d.delete();
    endtask

    initial begin
        // reset state
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_wren", 32'(imem_wr_en), 0);
        chk("rst_addr", 32'(imem_wr_addr), 0);
        chk("rst_data", 32'(imem_wr_data), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_run", 32'(core_run), 0);
        chk("rst_ovf", 32'(overflow_err), 0);
        chk("rst_wc", 32'(word_count), 0);
        wq_a.delete();
        wq_d.delete();

        // basic three-word program
        start();
        chk("b_ready", 32'(in_ready), 1);
        send(16'h1234);
        send(16'h2345);
        send(16'hF000);
        chk("b_done", 32'(load_done), 1);
        chk("b_run_early", 32'(core_run), 0);
        chk("b_ready_off", 32'(in_ready), 0);
        chk("b_wc", 32'(word_count), 3);
        tick();
        chk("b_run", 32'(core_run), 1);
        chk("b_done2", 32'(load_done), 1);
        chk("b_wren_off", 32'(imem_wr_en), 0);
`ifdef LOADER_CHECKSUM_EN
        chk("b_cks", 32'(load_checksum), 32'(16'h1234 ^ 16'h2345 ^ 16'hF000));
`endif
        check_writes("b", 3, {16'h0, 16'hF000, 16'h2345, 16'h1234});

        // restart from DONE
        start();
        chk("r_run", 32'(core_run), 0);
        chk("r_done", 32'(load_done), 0);
        chk("r_ready", 32'(in_ready), 1);
        chk("r_wc", 32'(word_count), 0);
        send(16'hF0AA);
        chk("r_done2", 32'(load_done), 1);
        chk("r_wc2", 32'(word_count), 1);
        tick();
        chk("r_run2", 32'(core_run), 1);
`ifdef LOADER_CHECKSUM_EN
        chk("r_cks", 32'(load_checksum), 32'h0000F0AA);
`endif
        check_writes("r", 1, {48'h0, 16'hF0AA});

        // source stalls, plus an ignored load_start mid-load
        start();
        send(16'h1111);
        tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        tick();
        send(16'h2222);
        tick();
        tick();
        tick();
        send(16'hF333);
        chk("s_done", 32'(load_done), 1);
        chk("s_wc", 32'(word_count), 3);
        check_writes("s", 3, {16'h0, 16'hF333, 16'h2222, 16'h1111});

        // overflow: four non-END words fill memory
        tick();
        start();
        send(16'h1001);
        send(16'h1002);
        send(16'h1003);
        send(16'h1004);
        chk("o_ovf", 32'(overflow_err), 1);
        chk("o_done", 32'(load_done), 0);
        chk("o_run", 32'(core_run), 0);
        chk("o_wc", 32'(word_count), 4);
        chk("o_ready", 32'(in_ready), 0);
        tick();
        chk("o_ovf2", 32'(overflow_err), 1);
        chk("o_run2", 32'(core_run), 0);
        chk("o_wren_off", 32'(imem_wr_en), 0);
`ifdef LOADER_CHECKSUM_EN
        chk("o_cks", 32'(load_checksum), 32'(16'h1001 ^ 16'h1002 ^ 16'h1003 ^ 16'h1004));
`endif
        check_writes("o", 4, {16'h1004, 16'h1003, 16'h1002, 16'h1001});

        // END on the last address wins over overflow
        start();
        chk("e_ovf_clr", 32'(overflow_err), 0);
        chk("e_wc", 32'(word_count), 0);
        chk("e_ready", 32'(in_ready), 1);
        send(16'h1001);
        send(16'h1002);
        send(16'h1003);
        send(16'hF004);
        chk("e_done", 32'(load_done), 1);
        chk("e_ovf", 32'(overflow_err), 0);
        chk("e_wc2", 32'(word_count), 4);
        tick();
        chk("e_run", 32'(core_run), 1);
        check_writes("e", 4, {16'hF004, 16'h1003, 16'h1002, 16'h1001});

        // reset during load, load_start coincident with reset
        start();
        send(16'h5555);
        send(16'h6666);
        in_valid   = 1'b1;
        in_data    = 16'h7777;
        reset      = 1'b1;
        load_start = 1'b1;
        tick();
        reset      = 1'b0;
        load_start = 1'b0;
        chk("a_ready", 32'(in_ready), 0);
        chk("a_run", 32'(core_run), 0);
        chk("a_wc", 32'(word_count), 0);
        chk("a_wren", 32'(imem_wr_en), 0);
        chk("a_done", 32'(load_done), 0);

        // in_valid held high in IDLE
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("i_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        check_writes("a", 2, {32'h0, 16'h6666, 16'h5555});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
